// File: rtl/if_id_queue_if.sv
// IF->ID handshake bundle: fetch side (in_*), decode side (out_*), flush/freeze.
// master = fetch/decode pair driving the queue; slave = the queue itself.
interface if_id_queue_if #(
  parameter int ADDRESS_LEN = 32
);
  logic                   flush;
  logic                   in_valid;
  logic [ADDRESS_LEN-1:0] in_pc;
  logic [ADDRESS_LEN-1:0] in_instruction;
  logic                   in_ready;
  logic                   freeze;
  logic                   out_valid;
  logic [ADDRESS_LEN-1:0] out_pc;
  logic [ADDRESS_LEN-1:0] out_instruction;

  modport master (
    output flush,
    output in_valid,
    output in_pc,
    output in_instruction,
    input  in_ready,
    output freeze,
    input  out_valid,
    input  out_pc,
    input  out_instruction
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_pc,
    input  in_instruction,
    output in_ready,
    input  freeze,
    output out_valid,
    output out_pc,
    output out_instruction
  );
endinterface

// File: rtl/if_id_queue.sv
// IF->ID decoupling FIFO: clk, rst (async, active-high), bus (if_id_queue_if.slave).
// IF_ID_BYPASS_EN: forward input straight to the head when the queue is empty.
module if_id_queue #(
  parameter int ADDRESS_LEN = 32,
  parameter int DEPTH       = 4
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

  typedef struct packed {
    logic [ADDRESS_LEN-1:0] pc;
    logic [ADDRESS_LEN-1:0] instruction;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic full;
  logic empty;
  logic byp;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

`ifdef IF_ID_BYPASS_EN
  assign byp = empty & bus.in_valid & ~bus.flush;
`else
  assign byp = 1'b0;
`endif

  assign bus.in_ready = ~full;

  always_comb begin
    bus.out_valid       = 1'b0;
    bus.out_pc          = '0;
    bus.out_instruction = '0;
    unique case (1'b1)
      !empty: begin
        bus.out_valid       = 1'b1;
        bus.out_pc          = mem[rd_ptr].pc;
        bus.out_instruction = mem[rd_ptr].instruction;
      end
      byp: begin
        bus.out_valid       = 1'b1;
        bus.out_pc          = bus.in_pc;
        bus.out_instruction = bus.in_instruction;
      end
      default: ;
    endcase
  end

  assign push = bus.in_valid & ~full & ~bus.flush;
  assign pop  = bus.out_valid & ~bus.freeze & ~bus.flush;

  // A word forwarded and consumed in the same cycle never touches storage.
  assign wr_en = push & ~(byp & pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{pc: bus.in_pc, instruction: bus.in_instruction};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_if_id_queue;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] K = 32'hDEAD_0000;
`ifdef IF_ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          t_fl, t_iv, t_fz;
  logic [AW-1:0] t_pc, t_ins;

  if_id_queue_if #(.ADDRESS_LEN(AW)) bus();

  assign bus.flush          = t_fl;
  assign bus.in_valid       = t_iv;
  assign bus.in_pc          = t_pc;
  assign bus.in_instruction = t_ins;
  assign bus.freeze         = t_fz;

  if_id_queue #(.ADDRESS_LEN(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] ins;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic          fl;
    logic          iv;
    logic          fz;
    logic [AW-1:0] pc;
    logic          rdy;
    logic          vld;
    logic [AW-1:0] epc;
  } vec_t;
  vec_t tbl[16];

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic iv, logic [AW-1:0] pc,
                       logic [AW-1:0] ins, logic fz);
    t_fl  = fl;
    t_iv  = iv;
    t_pc  = pc;
    t_ins = ins;
    t_fz  = fz;
  endtask

  // Entered at posedge+1 with inputs driven; leaves at next posedge+1.
  task automatic step(string tag, output logic a_rdy, output logic a_vld,
                      output logic [AW-1:0] a_pc);
    bit            byp_now, e_rdy, e_vld, pop_m, push_m;
    logic [AW-1:0] e_pc, e_ins;
    @(negedge clk);
    byp_now = BYP && q.size() == 0 && t_iv && !t_fl;
    e_rdy   = q.size() < DEPTH;
    e_vld   = q.size() > 0 || byp_now;
    e_pc    = '0;
    e_ins   = '0;
    if (q.size() > 0) begin
      e_pc  = q[0].pc;
      e_ins = q[0].ins;
    end else if (byp_now) begin
      e_pc  = t_pc;
      e_ins = t_ins;
    end
    a_rdy = bus.in_ready;
    a_vld = bus.out_valid;
    a_pc  = bus.out_pc;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(e_rdy));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(e_vld));
    chk({tag, " out_pc"}, bus.out_pc, e_pc);
    chk({tag, " out_instruction"}, bus.out_instruction, e_ins);
    @(posedge clk);
    if (t_fl) begin
      q.delete();
    end else begin
      pop_m  = e_vld && !t_fz;
      push_m = t_iv && e_rdy;
      if (!(byp_now && pop_m)) begin
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back('{pc: t_pc, ins: t_ins});
      end
    end
    #1;
  endtask

  task automatic cyc(string tag, logic fl, logic iv, logic [AW-1:0] pc,
                     logic fz);
    logic r, v;
    logic [AW-1:0] p;
    drive(fl, iv, pc, pc ^ K, fz);
    step(tag, r, v, p);
  endtask

  initial begin
    logic          r, v;
    logic [AW-1:0] p;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 1'b1, 32'h04};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0C};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h10};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 1'b1, 32'h10};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 32'h14};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h18};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h1C};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h20};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00};

    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset in_ready", 32'(bus.in_ready), 32'h1);
    chk("reset out_pc", bus.out_pc, 32'h0);
    chk("reset out_instruction", bus.out_instruction, 32'h0);
    rst = 1'b0;
    q.delete();

`ifndef IF_ID_BYPASS_EN
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].pc ^ K, tbl[i].fz);
      step($sformatf("vec%0d", i), r, v, p);
      chk($sformatf("vec%0d tbl_ready", i), 32'(r), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d tbl_valid", i), 32'(v), 32'(tbl[i].vld));
      chk($sformatf("vec%0d tbl_pc", i), p, tbl[i].epc);
    end
`endif

    // async reset mid-cycle with three entries queued
    cyc("rq0", 1'b0, 1'b1, 32'h100, 1'b1);
    cyc("rq1", 1'b0, 1'b1, 32'h104, 1'b1);
    cyc("rq2", 1'b0, 1'b1, 32'h108, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst out_pc", bus.out_pc, 32'h0);
    chk("midrst out_instruction", bus.out_instruction, 32'h0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    cyc("rp0", 1'b0, 1'b1, 32'h4, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    step("rp1", r, v, p);
    chk("post-reset head pc", p, 32'h4);
    chk("post-reset rd_ptr", 32'(dut.rd_ptr), 32'h0);

    // flush with a word presented, freeze also high
    cyc("fl0", 1'b0, 1'b1, 32'h200, 1'b1);
    cyc("fl1", 1'b0, 1'b1, 32'h204, 1'b1);
    cyc("fl2", 1'b1, 1'b1, 32'h40, 1'b1);
    chk("flush count", 32'(dut.count), 32'h0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    step("fl3", r, v, p);
    chk("after flush out_valid", 32'(v), 32'h0);
    chk("after flush in_ready", 32'(r), 32'h1);
    cyc("fl4", 1'b0, 1'b0, 32'h0, 1'b0);

    // pointer wrap with occupancy cycling 1..3
    cyc("wr_s", 1'b0, 1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if ((i % 4) < 2)
        cyc($sformatf("wrap%0d", i), 1'b0, 1'b1, 32'h304 + 32'(4 * i), 1'b1);
      else
        cyc($sformatf("wrap%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
    end
    cyc("wrap_ff", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("freeze+flush count", 32'(dut.count), 32'h0);
    cyc("wrap_e", 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef IF_ID_BYPASS_EN
    drive(1'b0, 1'b1, 32'h80, 32'h80 ^ K, 1'b0);
    step("byp0", r, v, p);
    chk("bypass same-cycle pc", p, 32'h80);
    chk("bypass count stays 0", 32'(dut.count), 32'h0);
    drive(1'b0, 1'b1, 32'h80, 32'h80 ^ K, 1'b1);
    step("byp1", r, v, p);
    chk("bypass frozen pc", p, 32'h80);
    chk("bypass frozen count", 32'(dut.count), 32'h1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    step("byp2", r, v, p);
    chk("bypass held pc", p, 32'h80);
    cyc("byp3", 1'b0, 1'b0, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0,
            $urandom,
            $urandom,
            $urandom_range(0, 2) == 0);
      step("rand", r, v, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
